// File: rtl/gmp_stuff_or_data_lanes_if.sv
// Beat bus between the frame parameter source, the stuff/data decision block and the lane mapper.
interface gmp_stuff_or_data_lanes_if #(
  parameter int MPT_W = 8,
  parameter int LANES = 4
);
  localparam int CW = $clog2(LANES + 1);

  logic [MPT_W-1:0] pm;
  logic [MPT_W-1:0] cm;
  logic             valid_in;
  logic             sof;
  logic             valid_out;
  logic             sof_out;
  logic             eof_out;
  logic [LANES-1:0] ds;
  logic [CW-1:0]    dcount;
  logic             input_err;
  logic             err_sof_early;
  logic             err_sof_late;

  modport master (
    output pm, cm, valid_in, sof,
    input  valid_out, sof_out, eof_out, ds, dcount,
    input  input_err, err_sof_early, err_sof_late
  );

  modport slave (
    input  pm, cm, valid_in, sof,
    output valid_out, sof_out, eof_out, ds, dcount,
    output input_err, err_sof_early, err_sof_late
  );
endinterface

// File: rtl/gmp_stuff_or_data_lanes.sv
// Multi-lane sigma-delta stuff/data decision: LANES consecutive payload positions per beat,
// lanes chained combinationally through the running accumulator.
module gmp_sd_lane #(
  parameter int W = 8
) (
  input  logic [W:0]   a_in,
  input  logic [W-1:0] cm,
  input  logic [W-1:0] pm,
  output logic         d,
  output logic [W:0]   a_out
);
  logic [W:0] s;

  assign s     = a_in + {1'b0, cm};
  assign d     = (s >= {1'b0, pm});
  assign a_out = d ? s - {1'b0, pm} : s;
endmodule

module gmp_stuff_or_data_lanes #(
  parameter int MPT_W = 8,
  parameter int LANES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  gmp_stuff_or_data_lanes_if.slave bus
);
  localparam int LG = $clog2(LANES);
  localparam int CW = $clog2(LANES + 1);
  // pm must be a whole number of beats
  localparam logic [MPT_W-1:0] LANE_MASK = MPT_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_SOF} state_t;

  state_t           state;
  logic [MPT_W-1:0] pm_r, cm_r, beats_r, beat_cnt;
  logic [MPT_W:0]   acc;

  logic             start, bad, emit, last;
  logic [MPT_W-1:0] pm_v, cm_v, beats_v, cnt_v;
  logic [LANES:0][MPT_W:0] a;
  logic [LANES-1:0] ds_c;
  logic [CW-1:0]    dc_c;

  assign start   = bus.valid_in & bus.sof;
  assign bad     = (bus.pm == '0) | (bus.cm > bus.pm) | ((bus.pm & LANE_MASK) != '0);
  // A legal sof evaluates its own beat with the fresh parameters and a cleared accumulator
  assign pm_v    = start ? bus.pm : pm_r;
  assign cm_v    = start ? bus.cm : cm_r;
  assign beats_v = start ? (bus.pm >> LG) : beats_r;
  assign cnt_v   = start ? '0 : beat_cnt;
  assign last    = (cnt_v == beats_v - 1'b1);
  assign emit    = bus.valid_in & (bus.sof ? ~bad : (state == RUN));
  assign a[0]    = start ? '0 : acc;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      gmp_sd_lane #(.W(MPT_W)) u_lane (
        .a_in  (a[g]),
        .cm    (cm_v),
        .pm    (pm_v),
        .d     (ds_c[g]),
        .a_out (a[g+1])
      );
    end
  endgenerate

  always_comb begin
    dc_c = '0;
    for (int i = 0; i < LANES; i++) dc_c = dc_c + CW'(ds_c[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      pm_r              <= '0;
      cm_r              <= '0;
      beats_r           <= '0;
      beat_cnt          <= '0;
      acc               <= '0;
      bus.valid_out     <= 1'b0;
      bus.sof_out       <= 1'b0;
      bus.eof_out       <= 1'b0;
      bus.ds            <= '0;
      bus.dcount        <= '0;
      bus.input_err     <= 1'b0;
      bus.err_sof_early <= 1'b0;
      bus.err_sof_late  <= 1'b0;
    end else begin
      bus.valid_out     <= 1'b0;
      bus.sof_out       <= 1'b0;
      bus.eof_out       <= 1'b0;
      bus.ds            <= '0;
      bus.dcount        <= '0;
      bus.input_err     <= 1'b0;
      bus.err_sof_early <= 1'b0;
      bus.err_sof_late  <= 1'b0;

      if (start) begin
        bus.err_sof_early <= (state == RUN) && (beat_cnt != '0);
        if (bad) begin
          bus.input_err <= 1'b1;
          state         <= IDLE;
          beat_cnt      <= '0;
        end else begin
          pm_r        <= bus.pm;
          cm_r        <= bus.cm;
          beats_r     <= beats_v;
          bus.sof_out <= 1'b1;
        end
      end else if (bus.valid_in && state == WAIT_SOF) begin
        bus.err_sof_late <= 1'b1;
        state            <= IDLE;
      end

      if (emit) begin
        bus.valid_out <= 1'b1;
        bus.ds        <= ds_c;
        bus.dcount    <= dc_c;
        bus.eof_out   <= last;
        acc           <= a[LANES];
        if (last) begin
          beat_cnt <= '0;
          state    <= WAIT_SOF;
        end else begin
          beat_cnt <= cnt_v + 1'b1;
          state    <= RUN;
        end
      end
    end
  end
endmodule

// File: tb/tb_gmp_stuff_or_data_lanes.sv
// Directed bench: a behavioural frame model pushes the expected output slot of every beat,
// which is popped and compared one cycle later.
module tb_gmp_stuff_or_data_lanes;
  localparam int L = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gmp_stuff_or_data_lanes_if #(.MPT_W(W), .LANES(L)) bus ();

  gmp_stuff_or_data_lanes #(.MPT_W(W), .LANES(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic         v;
    logic         s;
    logic         e;
    logic [L-1:0] ds;
    logic [2:0]   dc;
    logic         ie;
    logic         ee;
    logic         le;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_WAIT} mode_t;

  exp_t  q[$];
  string tq[$];
  int    n_cmp = 0;
  int    n_err = 0;
  mode_t m = M_IDLE;
  int    fpm, fcm, fbeats, fb;

  // Reference rule: position j (1-based) is data iff (j*cm) mod pm < cm
  function automatic logic [L-1:0] ref_ds(input int p, input int c, input int b);
    logic [L-1:0] r;
    for (int k = 0; k < L; k++) begin
      int j;
      j = b * L + k + 1;
      r[k] = ((j * c) % p) < c;
    end
    return r;
  endfunction

  function automatic exp_t emit_exp();
    exp_t e;
    e    = '0;
    e.v  = 1'b1;
    e.ds = ref_ds(fpm, fcm, fb);
    e.dc = 3'($countones(e.ds));
    e.e  = (fb == fbeats - 1);
    fb   = fb + 1;
    m    = e.e ? M_WAIT : M_RUN;
    return e;
  endfunction

  task automatic step(input logic r, input logic vi, input logic s,
                      input int p, input int c, input string tag);
    exp_t e, o;
    string t;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      t = tq.pop_front();
      o = {bus.valid_out, bus.sof_out, bus.eof_out, bus.ds, bus.dcount,
           bus.input_err, bus.err_sof_early, bus.err_sof_late};
      n_cmp++;
      assert (o === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", t, o, e);
      end
    end
    rst_n        = r;
    bus.valid_in = vi;
    bus.sof      = s;
    bus.pm       = 8'(p);
    bus.cm       = 8'(c);

    e = '0;
    if (!r) m = M_IDLE;
    else if (vi) begin
      if (s) begin
        logic early;
        early = (m == M_RUN);
        if (p == 0 || c > p || (p % L) != 0) begin
          e.ie = 1'b1;
          m    = M_IDLE;
        end else begin
          fpm = p; fcm = c; fbeats = p / L; fb = 0;
          e   = emit_exp();
          e.s = 1'b1;
        end
        e.ee = early;
      end else if (m == M_WAIT) begin
        e.le = 1'b1;
        m    = M_IDLE;
      end else if (m == M_RUN) begin
        e = emit_exp();
      end
    end
    q.push_back(e);
    tq.push_back(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.valid_in = 1'b0; bus.sof = 1'b0; bus.pm = '0; bus.cm = '0;

    step(0, 0, 0, 0, 0, "reset0");
    step(0, 1, 1, 8, 3, "reset1");
    step(1, 0, 0, 0, 0, "idle");

    // pm=8 cm=3: 0100 then 1010
    step(1, 1, 1, 8, 3, "f83_b0");
    step(1, 1, 0, 0, 0, "f83_b1");
    // same frame with gaps; sof during a gap must be ignored
    step(1, 1, 1, 8, 3, "gap_b0");
    step(1, 0, 1, 4, 1, "gap_idle");
    step(1, 0, 0, 0, 0, "gap_idle2");
    step(1, 1, 0, 0, 0, "gap_b1");

    step(1, 1, 1, 8, 8, "full_b0");
    step(1, 1, 0, 0, 0, "full_b1");
    step(1, 1, 1, 8, 0, "empty_b0");
    step(1, 1, 0, 0, 0, "empty_b1");
    step(1, 1, 1, 4, 3, "single");
    step(1, 1, 1, 4, 4, "single_full");

    // illegal parameters, then dropped non-sof beats
    step(1, 1, 1, 6, 2, "ill_pm6");
    step(1, 1, 0, 0, 0, "drop_after_ill");
    step(1, 1, 1, 8, 9, "ill_cm9");
    step(1, 1, 1, 0, 0, "ill_pm0");
    step(1, 1, 0, 0, 0, "drop_after_ill2");

    // early sof restarts the frame
    step(1, 1, 1, 16, 5, "p16_b0");
    step(1, 1, 0, 0, 0, "p16_b1");
    step(1, 1, 1, 8, 3, "early_sof");
    step(1, 1, 0, 0, 0, "early_b1");
    step(1, 1, 0, 0, 0, "late");
    step(1, 1, 0, 0, 0, "drop_idle");

    // early sof with illegal parameters reports both
    step(1, 1, 1, 16, 7, "p16c7_b0");
    step(1, 1, 0, 0, 0, "p16c7_b1");
    step(1, 1, 1, 0, 0, "early_ill");

    // reset mid-frame
    step(1, 1, 1, 8, 3, "rst_f_b0");
    step(0, 1, 0, 0, 0, "rst_mid");
    step(1, 1, 1, 8, 3, "post_rst_b0");
    step(1, 1, 0, 0, 0, "post_rst_b1");

    // longer frames back to back
    for (int b = 0; b < 4; b++) step(1, 1, (b == 0), 16, 7, "p16c7");
    for (int b = 0; b < 16; b++) step(1, 1, (b == 0), 64, 37, "p64c37");
    for (int b = 0; b < 8; b++) step(1, (b % 3) != 2, (b == 0), 20, 13, "p20c13");

    step(1, 0, 0, 0, 0, "flush0");
    step(1, 0, 0, 0, 0, "flush1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
